// File: rtl/memory_controller.sv
// memory_controller: arbitrates the byte-wide RAM port between instruction fetch and the load/store buffer.
// Define MEMORY_CONTROLLER_IO_STALL_EN to hold IO stores while io_buffer_full is high.
module memory_controller #(
  parameter int          LSB_TYPE_WIDTH = 4,
  parameter logic [31:0] IO_BASE        = 32'h0003_0000
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      flush,
  input  logic [7:0]                mem_din,
  output logic [7:0]                mem_dout,
  output logic [31:0]               mem_a,
  output logic                      mem_wr,
  input  logic                      io_buffer_full,
  input  logic                      if_en,
  input  logic [31:0]               if_addr,
  output logic                      if_rdy,
  output logic [31:0]               if_data,
  input  logic                      lsb_en,
  input  logic [31:0]               lsb_addr,
  input  logic [LSB_TYPE_WIDTH-1:0] lsb_type,
  input  logic [31:0]               lsb_write_data,
  output logic                      lsb_rdy,
  output logic [31:0]               lsb_read_data
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state;
  logic        last_lsb;
  logic        owner_lsb;
  logic        flushed;
  logic        wr_q;
  logic [2:0]  cnt;
  logic [2:0]  nbytes;
  logic [31:0] base_addr;
  logic [31:0] wdata;
  logic [31:0] buf_q;
  logic [31:0] buf_next;
  logic [1:0]  size_q;
  logic        zext;

  logic        lsb_block;
  logic        io_hold;
  logic        grant_lsb;
  logic        grant_if;
  logic        accept;
  logic        capture;
  logic [2:0]  req_n;
  logic [31:0] req_addr;
  logic        req_wr;
  logic [2:0]  cnt_inc;
  logic [2:0]  cap_idx;

  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [1:0] size,
                                              input logic zero_ext);
    case (size)
      2'b00:   return {{24{raw[7] & ~zero_ext}}, raw[7:0]};
      2'b01:   return {{16{raw[15] & ~zero_ext}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

`ifdef MEMORY_CONTROLLER_IO_STALL_EN
  assign lsb_block = lsb_type[3] & (lsb_addr >= IO_BASE) & io_buffer_full;
  assign io_hold   = (state == WRITE) & (base_addr >= IO_BASE) & io_buffer_full;
`else
  logic unused_io;
  assign lsb_block = 1'b0;
  assign io_hold   = 1'b0;
  assign unused_io = io_buffer_full ^ IO_BASE[0];
`endif

  // Round-robin on ties: the requester not served last wins.
  assign grant_lsb = lsb_en & ~lsb_block & (~if_en | ~last_lsb);
  assign grant_if  = if_en & ~grant_lsb;
  assign accept    = rdy_in & (state == IDLE) & ~flush & (grant_lsb | grant_if);
  assign req_n     = grant_lsb ? byte_count(lsb_type[1:0]) : 3'd4;
  assign req_addr  = grant_lsb ? lsb_addr : if_addr;
  assign req_wr    = grant_lsb & lsb_type[3];

  assign cnt_inc = cnt + 3'd1;
  assign cap_idx = cnt - 3'd1;
  assign capture = rdy_in & (state == READ) & ~flush & (cnt != 3'd0);

  always_comb begin
    buf_next = buf_q;
    buf_next[{cap_idx[1:0], 3'b000} +: 8] = mem_din;
  end

  assign mem_wr = wr_q & rdy_in & ~io_hold;

  // Transfer datapath: latched request and byte assembly buffer.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      base_addr <= req_addr;
      wdata     <= lsb_write_data;
      size_q    <= lsb_type[1:0];
      zext      <= lsb_type[2];
      buf_q     <= '0;
    end else if (capture) begin
      buf_q <= buf_next;
    end
  end

  // Sequencer: one byte per cycle; read capture trails the address by two edges.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state         <= IDLE;
      last_lsb      <= 1'b0;
      owner_lsb     <= 1'b0;
      flushed       <= 1'b0;
      wr_q          <= 1'b0;
      cnt           <= '0;
      nbytes        <= '0;
      mem_a         <= '0;
      mem_dout      <= '0;
      if_rdy        <= 1'b0;
      lsb_rdy       <= 1'b0;
      if_data       <= '0;
      lsb_read_data <= '0;
    end else if (rdy_in) begin
      if_rdy  <= 1'b0;
      lsb_rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            owner_lsb <= grant_lsb;
            last_lsb  <= grant_lsb;
            nbytes    <= req_n;
            cnt       <= '0;
            flushed   <= 1'b0;
            mem_a     <= req_addr;
            if (req_wr) begin
              state    <= WRITE;
              wr_q     <= 1'b1;
              mem_dout <= lsb_write_data[7:0];
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc < nbytes) mem_a <= base_addr + {29'b0, cnt_inc};
            if (cnt == nbytes) begin
              state <= DONE;
              if (owner_lsb) begin
                lsb_rdy       <= 1'b1;
                lsb_read_data <= extend_load(buf_next, size_q, zext);
              end else begin
                if_rdy  <= 1'b1;
                if_data <= buf_next;
              end
            end
          end
        end
        WRITE: begin
          // A flushed store is already committed: it completes silently.
          if (flush) flushed <= 1'b1;
          if (!io_hold) begin
            if (cnt_inc == nbytes) begin
              state <= DONE;
              wr_q  <= 1'b0;
              if (!(flushed | flush)) lsb_rdy <= 1'b1;
            end else begin
              cnt      <= cnt_inc;
              mem_a    <= base_addr + {29'b0, cnt_inc};
              mem_dout <= wdata[{cnt_inc[1:0], 3'b000} +: 8];
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_controller.sv
// Scoreboard bench for memory_controller: byte RAM model, expected queues for fetch, LSB and writes.
module tb_memory_controller;

  logic        clk;
  logic        rst_in;
  logic        rdy_in;
  logic        flush;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        if_en;
  logic [31:0] if_addr;
  logic        if_rdy;
  logic [31:0] if_data;
  logic        lsb_en;
  logic [31:0] lsb_addr;
  logic [3:0]  lsb_type;
  logic [31:0] lsb_write_data;
  logic        lsb_rdy;
  logic [31:0] lsb_read_data;

  memory_controller dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .if_en(if_en), .if_addr(if_addr), .if_rdy(if_rdy), .if_data(if_data),
    .lsb_en(lsb_en), .lsb_addr(lsb_addr), .lsb_type(lsb_type),
    .lsb_write_data(lsb_write_data), .lsb_rdy(lsb_rdy), .lsb_read_data(lsb_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int if_cnt = 0;
  int lsb_cnt = 0;
  int wr_cnt = 0;

  logic [7:0]  ram    [1024];
  logic [7:0]  shadow [1024];
  logic [31:0] if_q   [$];
  logic [32:0] lsb_q  [$];
  logic [39:0] wexp   [$];
  bit          grant_log [$];
  logic [39:0] we;
  logic [32:0] le;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] sh(input logic [31:0] a);
    return shadow[a[9:0]];
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    return {sh(a + 32'd3), sh(a + 32'd2), sh(a + 32'd1), sh(a)};
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [3:0] typ);
    logic [31:0] raw;
    logic signed [7:0]  sb;
    logic signed [15:0] shw;
    raw = model_word(a);
    sb  = raw[7:0];
    shw = raw[15:0];
    if (typ[1:0] == 2'b00) begin
      if (typ[2]) return {24'h0, raw[7:0]};
      return 32'(sb);
    end else if (typ[1:0] == 2'b01) begin
      if (typ[2]) return {16'h0, raw[15:0]};
      return 32'(shw);
    end
    return raw;
  endfunction

  function automatic int nbytes_of(input logic [3:0] typ);
    return (typ[1:0] == 2'b00) ? 1 : (typ[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic void push_writes(input logic [31:0] a, input int n, input logic [31:0] wd);
    for (int k = 0; k < n; k++) begin
      wexp.push_back({a + 32'(k), wd[8*k +: 8]});
      shadow[10'(a + 32'(k))] = wd[8*k +: 8];
    end
  endfunction

  // RAM: read data appears the cycle after its address.
  always @(posedge clk) begin
    if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
    mem_din <= ram[mem_a[9:0]];
  end

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    #2;
    if (rst_in) begin
      if (mem_wr) begin
        wr_cnt++;
        if (wexp.size() == 0) check_val("wr_spurious", 32'(wexp.size()), 32'd1);
        else begin
          we = wexp.pop_front();
          check_val("wr_addr", mem_a, we[39:8]);
          check_val("wr_data", 32'(mem_dout), 32'(we[7:0]));
        end
      end
      if (if_rdy) begin
        if_cnt++;
        grant_log.push_back(1'b0);
        if (if_q.size() == 0) check_val("if_spurious", 32'(if_q.size()), 32'd1);
        else check_val("if_data", if_data, if_q.pop_front());
      end
      if (lsb_rdy) begin
        lsb_cnt++;
        grant_log.push_back(1'b1);
        if (lsb_q.size() == 0) check_val("lsb_spurious", 32'(lsb_q.size()), 32'd1);
        else begin
          le = lsb_q.pop_front();
          if (!le[32]) check_val("lsb_data", lsb_read_data, le[31:0]);
        end
      end
    end
  end

  task automatic fetch_req(input logic [31:0] a);
    int lat;
    if_en = 1'b1;
    if_addr = a;
    if_q.push_back(model_word(a));
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat >= 1 && lat <= 4) check_val("fetch_addr", mem_a, a + 32'(lat - 1));
    end while (!if_rdy && lat < 40);
    check_val("fetch_rdy_seen", 32'(if_rdy), 32'd1);
    check_val("fetch_latency", 32'(lat), 32'd6);
    if_en = 1'b0;
    @(negedge clk);
    check_val("fetch_pulse_width", 32'(if_rdy), 32'd0);
  endtask

  task automatic lsb_req(input logic [31:0] a, input logic [3:0] typ, input logic [31:0] wd);
    int lat, n;
    n = nbytes_of(typ);
    lsb_en = 1'b1;
    lsb_addr = a;
    lsb_type = typ;
    lsb_write_data = wd;
    if (typ[3]) begin
      push_writes(a, n, wd);
      lsb_q.push_back({1'b1, 32'h0});
    end else begin
      lsb_q.push_back({1'b0, model_load(a, typ)});
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat >= 1 && lat <= n) check_val("lsb_addr", mem_a, a + 32'(lat - 1));
    end while (!lsb_rdy && lat < 40);
    check_val("lsb_rdy_seen", 32'(lsb_rdy), 32'd1);
    check_val("lsb_latency", 32'(lat), typ[3] ? 32'(n + 1) : 32'(n + 2));
    lsb_en = 1'b0;
    @(negedge clk);
    check_val("lsb_pulse_width", 32'(lsb_rdy), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, c0, l0, lt;
    for (int i = 0; i < 1024; i++) begin
      ram[i] = 8'(i * 37 + 5);
    end
    ram[10'h100] = 8'h11; ram[10'h101] = 8'h22; ram[10'h102] = 8'h33; ram[10'h103] = 8'h44;
    ram[10'h8] = 8'h80; ram[10'h9] = 8'h7F; ram[10'hA] = 8'h34; ram[10'hB] = 8'h92;
    for (int i = 0; i < 1024; i++) shadow[i] = ram[i];
    rst_in = 1'b0; rdy_in = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
    if_en = 1'b0; if_addr = '0; lsb_en = 1'b0; lsb_addr = '0; lsb_type = '0; lsb_write_data = '0;
    repeat (2) @(negedge clk);
    check_val("rst_mem_a", mem_a, 32'h0);
    check_val("rst_mem_dout", 32'(mem_dout), 32'h0);
    check_val("rst_mem_wr", 32'(mem_wr), 32'h0);
    check_val("rst_if_rdy", 32'(if_rdy), 32'h0);
    check_val("rst_lsb_rdy", 32'(lsb_rdy), 32'h0);
    check_val("rst_if_data", if_data, 32'h0);
    check_val("rst_lsb_read_data", lsb_read_data, 32'h0);
    rst_in = 1'b1;
    @(negedge clk);

    fetch_req(32'h100);
    lsb_req(32'h8, 4'b0000, 32'h0);
    lsb_req(32'h8, 4'b0100, 32'h0);
    lsb_req(32'hA, 4'b0001, 32'h0);
    lsb_req(32'hA, 4'b0101, 32'h0);
    lsb_req(32'h100, 4'b0010, 32'h0);

    w0 = wr_cnt;
    lsb_req(32'h20, 4'b1001, 32'hABCD1234);
    check_val("store_half_wr_cycles", 32'(wr_cnt - w0), 32'd2);
    lsb_req(32'h20, 4'b0101, 32'h0);
    lsb_req(32'hFFFF_FFFE, 4'b0010, 32'h0);

    // Fetch flushed in cycle E0+2: aborted silently.
    c0 = if_cnt;
    if_en = 1'b1; if_addr = 32'h100;
    repeat (3) @(negedge clk);
    flush = 1'b1; if_en = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    repeat (8) @(negedge clk);
    check_val("flush_fetch_no_rdy", 32'(if_cnt), 32'(c0));
    fetch_req(32'h104);

    // Word store flushed mid-way: all bytes land, no completion pulse.
    w0 = wr_cnt; l0 = lsb_cnt;
    lsb_en = 1'b1; lsb_addr = 32'h60; lsb_type = 4'b1010; lsb_write_data = 32'hDEADBEEF;
    push_writes(32'h60, 4, 32'hDEADBEEF);
    repeat (2) @(negedge clk);
    flush = 1'b1; lsb_en = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    repeat (6) @(negedge clk);
    check_val("flush_store_bytes", 32'(wr_cnt - w0), 32'd4);
    check_val("flush_store_no_rdy", 32'(lsb_cnt), 32'(l0));
    lsb_req(32'h60, 4'b0010, 32'h0);

    // rdy_in low freezes the transfer and masks mem_wr.
    w0 = wr_cnt;
    lsb_en = 1'b1; lsb_addr = 32'h50; lsb_type = 4'b1000; lsb_write_data = 32'h0000_005A;
    push_writes(32'h50, 1, 32'h5A);
    lsb_q.push_back({1'b1, 32'h0});
    @(negedge clk);
    rdy_in = 1'b0;
    #1;
    check_val("freeze_mem_wr", 32'(mem_wr), 32'd0);
    check_val("freeze_mem_a", mem_a, 32'h50);
    repeat (2) @(negedge clk);
    rdy_in = 1'b1;
    lt = 0;
    do begin @(negedge clk); lt++; end while (!lsb_rdy && lt < 20);
    check_val("freeze_rdy_seen", 32'(lsb_rdy), 32'd1);
    lsb_en = 1'b0;
    @(negedge clk);
    check_val("freeze_wr_cycles", 32'(wr_cnt - w0), 32'd1);

`ifdef MEMORY_CONTROLLER_IO_STALL_EN
    w0 = wr_cnt;
    io_buffer_full = 1'b1;
    lsb_en = 1'b1; lsb_addr = 32'h0003_0000; lsb_type = 4'b1000; lsb_write_data = 32'h77;
    push_writes(32'h0003_0000, 1, 32'h77);
    lsb_q.push_back({1'b1, 32'h0});
    repeat (3) begin
      @(negedge clk);
      #1;
      check_val("io_stall_mem_wr", 32'(mem_wr), 32'd0);
    end
    io_buffer_full = 1'b0;
    lt = 0;
    do begin @(negedge clk); lt++; end while (!lsb_rdy && lt < 20);
    check_val("io_rdy_seen", 32'(lsb_rdy), 32'd1);
    lsb_en = 1'b0;
    @(negedge clk);
    check_val("io_wr_cycles", 32'(wr_cnt - w0), 32'd1);
`else
    io_buffer_full = 1'b1;
    lsb_req(32'h0003_0000, 4'b1000, 32'h77);
    io_buffer_full = 1'b0;
`endif

    // Asynchronous reset in the middle of a word store.
    lsb_en = 1'b1; lsb_addr = 32'h40; lsb_type = 4'b1010; lsb_write_data = 32'h01020304;
    push_writes(32'h40, 2, 32'h01020304);
    repeat (3) @(negedge clk);
    rst_in = 1'b0; lsb_en = 1'b0;
    #1;
    check_val("midrst_mem_a", mem_a, 32'h0);
    check_val("midrst_mem_dout", 32'(mem_dout), 32'h0);
    check_val("midrst_mem_wr", 32'(mem_wr), 32'h0);
    check_val("midrst_if_data", if_data, 32'h0);
    check_val("midrst_lsb_read_data", lsb_read_data, 32'h0);
    check_val("midrst_pending_writes", 32'(wexp.size()), 32'd0);
    @(negedge clk);
    rst_in = 1'b1;
    @(negedge clk);

    // Both requesters held high: grants alternate starting with the LSB.
    grant_log.delete();
    fork
      begin
        int lt_l;
        for (int i = 0; i < 3; i++) begin
          lsb_en = 1'b1;
          lsb_addr = 32'h8 + 32'(2 * i);
          lsb_type = (i == 1) ? 4'b0101 : 4'b0001;
          lsb_q.push_back({1'b0, model_load(32'h8 + 32'(2 * i), (i == 1) ? 4'b0101 : 4'b0001)});
          lt_l = 0;
          do begin @(negedge clk); lt_l++; end while (!lsb_rdy && lt_l < 60);
          check_val("rr_lsb_rdy", 32'(lsb_rdy), 32'd1);
        end
        lsb_en = 1'b0;
      end
      begin
        int lt_f;
        for (int i = 0; i < 3; i++) begin
          if_en = 1'b1;
          if_addr = 32'h100 + 32'(4 * i);
          if_q.push_back(model_word(32'h100 + 32'(4 * i)));
          lt_f = 0;
          do begin @(negedge clk); lt_f++; end while (!if_rdy && lt_f < 60);
          check_val("rr_if_rdy", 32'(if_rdy), 32'd1);
        end
        if_en = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    check_val("rr_grant_count", 32'(grant_log.size()), 32'd6);
    for (int i = 0; i < grant_log.size(); i++) begin
      check_val("rr_grant_order", 32'(grant_log[i]), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    check_val("final_if_queue", 32'(if_q.size()), 32'd0);
    check_val("final_lsb_queue", 32'(lsb_q.size()), 32'd0);
    check_val("final_wr_queue", 32'(wexp.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
